// File: rtl/window_result_streamer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | window_result_streamer_pkg: shared types and geometry helpers for     |
// | the corner-score return path.  Rev 1.0                                |
// +----------------------------------------------------------------------+
package window_result_streamer_pkg;

    localparam int SCORE_W = 16;
    localparam int CNT_W   = 9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } state_e;

    typedef struct packed {
        logic [SCORE_W-1:0] data;
        logic               corner;
        logic [CNT_W-1:0]   col;
        logic [CNT_W-1:0]   row;
        logic               sof;
        logic               eol;
        logic               eof;
    } entry_t;

    function automatic int rows_out(input int img_height, input int win);
        return img_height - win + 1;
    endfunction

    function automatic int valid_cols(input int img_width, input int win);
        return img_width - win + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/window_result_streamer_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fwft_fifo: single-clock first-word-fall-through FIFO; a push     |
// | into a full FIFO succeeds when a pop happens in the same cycle.       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module sync_fwft_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      w_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_count   = wr_ptr_q - rd_ptr_q;
    assign full_o    = (w_count == (AW+1)'(DEPTH));
    assign empty_o   = (w_count == '0);
    assign w_do_pop  = pop_i && !empty_o;
    assign w_do_push = push_i && (!full_o || w_do_pop);
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (w_do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage carries no reset; emptiness is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (w_do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

endmodule
`default_nettype wire

// File: rtl/window_result_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | window_result_streamer: masks, thresholds and raster-tags window      |
// | scores, then buffers them onto a ready/valid stream.  Rev 1.0         |
// +----------------------------------------------------------------------+
module window_result_streamer
    import window_result_streamer_pkg::*;
#(
    parameter int IMG_WIDTH  = 480,
    parameter int IMG_HEIGHT = 360,
    parameter int WIN        = 6,
    parameter int DATA_W     = SCORE_W,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_score,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] threshold,
    output logic [DATA_W-1:0] out_data,
    output logic              out_corner,
    output logic [8:0]        out_col,
    output logic [8:0]        out_row,
    output logic              out_sof,
    output logic              out_eol,
    output logic              out_eof,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              frame_done,
    output logic              overflow
);

    localparam logic [8:0] c_last_col  = 9'(IMG_WIDTH - 1);
    localparam logic [8:0] c_last_row  = 9'(rows_out(IMG_HEIGHT, WIN) - 1);
    localparam logic [8:0] c_max_valid = 9'(valid_cols(IMG_WIDTH, WIN) - 1);

    logic [8:0] col_q, col_d;
    logic [8:0] row_q, row_d;
    logic       overflow_q;
    state_e     state_q, state_d;
    logic       next_frame_q, next_frame_d;

    entry_t w_entry;
    entry_t w_head;
    logic   w_full;
    logic   w_empty;
    logic   w_pop;
    logic   w_wr_ok;
    logic   w_wr_sof;
    logic   w_wr_eof;
    logic   w_acc_eof;
    logic   w_col_valid;

    assign w_pop       = !w_empty && out_ready;
    assign w_wr_ok     = in_valid && (!w_full || w_pop);
    assign w_col_valid = (col_q <= c_max_valid);
    assign w_wr_sof    = w_wr_ok && w_entry.sof;
    assign w_wr_eof    = w_wr_ok && w_entry.eof;
    assign w_acc_eof   = w_pop && w_head.eof;

    always_comb begin
        w_entry.data   = w_col_valid ? in_score : '0;
        w_entry.corner = w_col_valid && (in_score > threshold);
        w_entry.col    = col_q;
        w_entry.row    = row_q;
        w_entry.sof    = (row_q == '0) && (col_q == '0);
        w_entry.eol    = (col_q == c_last_col);
        w_entry.eof    = (col_q == c_last_col) && (row_q == c_last_row);
    end

    // Counters advance on every in_valid, even a dropped one, to keep raster alignment.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (in_valid) begin
            if (col_q == c_last_col) begin
                col_d = '0;
                row_d = (row_q == c_last_row) ? 9'd0 : row_q + 9'd1;
            end else begin
                col_d = col_q + 9'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q      <= '0;
            row_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            if (in_valid && !w_wr_ok) overflow_q <= 1'b1;
        end
    end

    sync_fwft_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_i    (w_wr_ok),
        .wr_data_i (w_entry),
        .pop_i     (w_pop),
        .rd_data_o (w_head),
        .full_o    (w_full),
        .empty_o   (w_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            next_frame_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            next_frame_q <= next_frame_d;
        end
    end

    // next_frame_q remembers a sof written while the previous frame is still draining.
    always_comb begin
        state_d      = state_q;
        next_frame_d = next_frame_q;
        case (state_q)
            ST_IDLE: begin
                if (w_wr_sof) state_d = w_wr_eof ? ST_FLUSH : ST_STREAM;
            end
            ST_STREAM: begin
                if (w_wr_eof) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (w_acc_eof) begin
                    next_frame_d = 1'b0;
                    if (next_frame_q || w_wr_sof) begin
                        state_d = w_wr_eof ? ST_FLUSH : ST_STREAM;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (w_wr_sof) begin
                    next_frame_d = 1'b1;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                next_frame_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        frame_done = (state_q == ST_FLUSH) && w_acc_eof;
        overflow   = overflow_q;
        out_valid  = !w_empty;
        out_data   = '0;
        out_corner = 1'b0;
        out_col    = '0;
        out_row    = '0;
        out_sof    = 1'b0;
        out_eol    = 1'b0;
        out_eof    = 1'b0;
        if (!w_empty) begin
            out_data   = w_head.data;
            out_corner = w_head.corner;
            out_col    = w_head.col;
            out_row    = w_head.row;
            out_sof    = w_head.sof;
            out_eol    = w_head.eol;
            out_eof    = w_head.eof;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_window_result_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_window_result_streamer: table vectors plus queue scoreboard for    |
// | the 8x7 / WIN=6 configuration.  Rev 1.0                               |
// +----------------------------------------------------------------------+
module tb_window_result_streamer;
    import window_result_streamer_pkg::*;

    localparam int W     = 8;
    localparam int H     = 7;
    localparam int WN    = 6;
    localparam int ROWS  = H - WN + 1;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] in_score = '0;
    logic        in_valid = 1'b0;
    logic [15:0] threshold = 16'd2;
    logic [15:0] out_data;
    logic        out_corner;
    logic [8:0]  out_col;
    logic [8:0]  out_row;
    logic        out_sof, out_eol, out_eof, out_valid;
    logic        out_ready = 1'b0;
    logic        frame_done, overflow;

    window_result_streamer #(
        .IMG_WIDTH (W), .IMG_HEIGHT (H), .WIN (WN), .DATA_W (16), .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk (clk), .reset (reset), .in_score (in_score), .in_valid (in_valid),
        .threshold (threshold), .out_data (out_data), .out_corner (out_corner),
        .out_col (out_col), .out_row (out_row), .out_sof (out_sof), .out_eol (out_eol),
        .out_eof (out_eof), .out_valid (out_valid), .out_ready (out_ready),
        .frame_done (frame_done), .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic        corner;
        logic [8:0]  col;
        logic [8:0]  row;
        logic        sof, eol, eof;
    } exp_t;

    typedef struct {
        logic [15:0] score;
        logic [15:0] data;
        logic        corner, sof, eol, eof;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[16];
    int   checks = 0;
    int   failures = 0;
    int   m_col = 0;
    int   m_row = 0;
    logic m_ovf = 1'b0;
    int   fd_seen = 0;
    logic idle_between = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive, sample mid-cycle, compare against the queue head, update the model.
    task automatic cycle(input logic v, input logic [15:0] s, input logic rdy);
        exp_t e;
        logic ok;
        @(negedge clk);
        in_valid = v; in_score = s; out_ready = rdy;
        #1;
        chk("overflow", overflow, m_ovf);
        chk("out_valid", out_valid, sb.size() > 0);
        if (sb.size() > 0) begin
            e = sb[0];
            chk("beat", {out_data, out_corner, out_col, out_row, out_sof, out_eol, out_eof},
                {e.data, e.corner, e.col, e.row, e.sof, e.eol, e.eof});
        end
        if (fd_seen == 1 && dut.state_q == ST_IDLE) idle_between = 1'b1;
        if (frame_done) fd_seen++;
        if (sb.size() > 0 && rdy) void'(sb.pop_front());
        if (v) begin
            ok       = (m_col <= W - WN);
            e.data   = ok ? s : 16'd0;
            e.corner = ok && (s > threshold);
            e.col    = 9'(m_col);
            e.row    = 9'(m_row);
            e.sof    = (m_col == 0) && (m_row == 0);
            e.eol    = (m_col == W - 1);
            e.eof    = (m_col == W - 1) && (m_row == ROWS - 1);
            if (sb.size() < DEPTH) sb.push_back(e);
            else m_ovf = 1'b1;
            if (m_col == W - 1) begin
                m_col = 0;
                m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
            end else begin
                m_col++;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        m_col = 0; m_row = 0; m_ovf = 1'b0;
        fd_seen = 0; idle_between = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 16'd0, 1'b1);
    endtask

    initial begin
        tbl[0]  = '{16'd1,  16'd1,  1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{16'd2,  16'd2,  1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{16'd3,  16'd3,  1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{16'd4,  16'd0,  1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{16'd5,  16'd0,  1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{16'd6,  16'd0,  1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{16'd7,  16'd0,  1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{16'd8,  16'd0,  1'b0, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{16'd9,  16'd9,  1'b1, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{16'd10, 16'd10, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{16'd11, 16'd11, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{16'd12, 16'd0,  1'b0, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{16'd13, 16'd0,  1'b0, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{16'd14, 16'd0,  1'b0, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{16'd15, 16'd0,  1'b0, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{16'd16, 16'd0,  1'b0, 1'b0, 1'b1, 1'b1};

        @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_outputs", {out_data, out_corner, out_col, out_row, out_sof, out_eol,
                              out_eof, out_valid, frame_done, overflow}, '0);

        // Threshold and masking, straight-through flow.
        do_reset();
        threshold = 16'd2;
        for (int i = 0; i <= 16; i++) begin
            cycle(i < 16, tbl[i < 16 ? i : 15].score, 1'b1);
            if (i > 0) begin
                chk("tbl_data", out_data, tbl[i-1].data);
                chk("tbl_flags", {out_valid, out_corner, out_sof, out_eol, out_eof},
                    {1'b1, tbl[i-1].corner, tbl[i-1].sof, tbl[i-1].eol, tbl[i-1].eof});
                chk("tbl_frame_done", frame_done, i == 16);
            end
        end
        drain(2);
        chk("tbl_fd_count", fd_seen, 1);

        // Backpressure: fill completely, then drain in order.
        do_reset();
        threshold = 16'd100;
        for (int i = 0; i < 16; i++) cycle(1'b1, 16'($urandom_range(0, 200)), 1'b0);
        drain(18);
        chk("bp_no_overflow", overflow, 1'b0);

        // Overflow: 17th write dropped, raster alignment kept.
        do_reset();
        threshold = 16'd2;
        for (int i = 0; i < 17; i++) cycle(1'b1, 16'(i + 1), 1'b0);
        cycle(1'b0, 16'd0, 1'b0);
        chk("ovf_set", overflow, 1'b1);
        drain(18);
        for (int i = 0; i < 15; i++) cycle(1'b1, 16'(i + 40), 1'b1);
        drain(3);
        cycle(1'b1, 16'd77, 1'b1);
        cycle(1'b0, 16'd0, 1'b1);
        chk("ovf_realign_sof", {out_valid, out_sof, out_col, out_row}, {1'b1, 1'b1, 9'd0, 9'd0});
        chk("ovf_sticky", overflow, 1'b1);
        drain(2);

        // Full FIFO with simultaneous push and pop.
        do_reset();
        for (int i = 0; i < 16; i++) cycle(1'b1, 16'(i + 1), 1'b0);
        cycle(1'b1, 16'd99, 1'b1);
        cycle(1'b0, 16'd0, 1'b0);
        chk("full_pushpop_count", dut.u_fifo.w_count, 16);
        chk("full_pushpop_ovf", overflow, 1'b0);
        drain(18);

        // Reset in the middle of a frame.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 16'(i + 1), 1'b1);
        do_reset();
        cycle(1'b1, 16'd20, 1'b1);
        cycle(1'b1, 16'd21, 1'b1);
        chk("rst_first_sof", {out_valid, out_sof, out_col, out_row}, {1'b1, 1'b1, 9'd0, 9'd0});
        for (int i = 0; i < 14; i++) cycle(1'b1, 16'(i + 22), 1'b1);
        drain(4);
        chk("rst_fd_once", fd_seen, 1);

        // Back-to-back frames with toggling ready.
        do_reset();
        for (int i = 0; i < 32; i++) cycle(1'b1, 16'(i), i[0]);
        drain(40);
        chk("b2b_fd_twice", fd_seen, 2);
        chk("b2b_no_idle", idle_between, 1'b0);
        chk("b2b_end_idle", dut.state_q, ST_IDLE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
